// File: rtl/coef_ram_arbiter.sv
// coef_ram_arbiter: queues SPI coefficient writes (2 entries) and shares the single-port coefficient RAM with FIR reads.
// Define COEF_STARVE_GUARD_EN to force a queued SPI write after MAX_FIR_BURST consecutive FIR grants.
module coef_ram_arbiter #(
    parameter int FILTER_BITS   = 2,
    parameter int TAP_BITS      = 8,
    parameter int COEF_WIDTH    = 16,
    parameter int MAX_FIR_BURST = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            coef_wr_stb,
    input  logic [7:0]                      coef_lsb,
    input  logic [7:0]                      coef_msb,
    input  logic [7:0]                      filter_sel,
    input  logic [7:0]                      taps_per_filter,
    input  logic                            tap_ptr_clr,
    input  logic                            ovf_clr,
    input  logic                            fir_req,
    input  logic [FILTER_BITS+TAP_BITS-1:0] fir_addr,
    output logic                            fir_gnt,
    output logic [COEF_WIDTH-1:0]           fir_rdata,
    output logic                            fir_rvalid,
    output logic                            ram_en,
    output logic                            ram_we,
    output logic [FILTER_BITS+TAP_BITS-1:0] ram_addr,
    output logic [COEF_WIDTH-1:0]           ram_wdata,
    input  logic [COEF_WIDTH-1:0]           ram_rdata,
    output logic [TAP_BITS-1:0]             tap_ptr,
    output logic                            busy,
    output logic                            overflow
);
    localparam int AW = FILTER_BITS + TAP_BITS;
    localparam int EW = AW + COEF_WIDTH;

    logic [TAP_BITS-1:0] tap_q, tap_d, tap_wr, tap_last;
    logic [EW-1:0]       ent_q [2];
    logic [EW-1:0]       ent_d [2];
    logic [EW-1:0]       new_ent;
    logic [1:0]          cnt_q, cnt_d, cnt_pop;
    logic                ovf_q, ovf_d, gnt_q, force_d;
    logic                fir_acc, pop, push, drop;
    logic                en_q, en_d, we_q, we_d, rd_q, rvalid_q;
    logic [AW-1:0]       addr_q, addr_d;
    logic [COEF_WIDTH-1:0] wdata_q, wdata_d;
    logic                unused_filter_hi;

    assign unused_filter_hi = ^filter_sel;

    always_comb begin
        fir_acc  = fir_req && gnt_q;
        pop      = !fir_acc && (cnt_q != 2'd0);
        drop     = coef_wr_stb && (cnt_q == 2'd2) && !pop;
        push     = coef_wr_stb && !drop;
        tap_wr   = tap_ptr_clr ? '0 : tap_q;
        tap_last = TAP_BITS'(taps_per_filter - 8'd1);
        tap_d    = coef_wr_stb ? ((tap_wr >= tap_last) ? '0 : tap_wr + TAP_BITS'(1)) : tap_wr;
        new_ent  = {filter_sel[FILTER_BITS-1:0], tap_wr, COEF_WIDTH'({coef_msb, coef_lsb})};
        cnt_pop  = cnt_q - {1'b0, pop};
        ent_d[0] = (push && cnt_pop == 2'd0) ? new_ent : (pop ? ent_q[1] : ent_q[0]);
        ent_d[1] = (push && cnt_pop == 2'd1) ? new_ent : ent_q[1];
        cnt_d    = cnt_pop + {1'b0, push};
        ovf_d    = drop || (ovf_q && !ovf_clr);
        en_d     = fir_acc || pop;
        we_d     = pop;
        addr_d   = fir_acc ? fir_addr : (pop ? ent_q[0][EW-1:COEF_WIDTH] : addr_q);
        wdata_d  = pop ? ent_q[0][COEF_WIDTH-1:0] : wdata_q;
    end

`ifdef COEF_STARVE_GUARD_EN
    localparam int BW = $clog2(MAX_FIR_BURST + 1);
    logic [BW-1:0] burst_q, burst_d;

    // Saturates so a write queued after a long burst is still forced out.
    always_comb begin
        burst_d = fir_acc ? ((burst_q == BW'(MAX_FIR_BURST)) ? burst_q : burst_q + BW'(1)) : '0;
        force_d = (burst_d == BW'(MAX_FIR_BURST)) && (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) burst_q <= '0;
        else       burst_q <= burst_d;
    end
`else
    localparam int UNUSED_MAX_FIR_BURST = MAX_FIR_BURST;
    assign force_d = 1'b0;
`endif

    // Grant is registered from next state so fir_req never reaches fir_gnt combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_q    <= '0;
            ent_q    <= '{default: '0};
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            gnt_q    <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            tap_q    <= tap_d;
            ent_q    <= ent_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            gnt_q    <= !force_d;
            en_q     <= en_d;
            we_q     <= we_d;
            rd_q     <= fir_acc;
            rvalid_q <= rd_q;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign fir_gnt    = gnt_q;
    assign fir_rdata  = ram_rdata;
    assign fir_rvalid = rvalid_q;
    assign ram_en     = en_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign tap_ptr    = tap_q;
    assign busy       = cnt_q != 2'd0;
    assign overflow   = ovf_q;
endmodule
